// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 8N1 frames at BAUD on a synchronized rx line, with an
// optional filter that drops System Real-Time bytes before they reach MIDIbyte.
module midi_uart_rx #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 31_250,
    parameter bit FILTER_RT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] MIDIbyte,
    output logic       ready,
    output logic       framing_error
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    // System Real-Time messages occupy 0xF8..0xFF
    function automatic logic is_realtime(input logic [7:0] b);
        return (b[7:3] == 5'b11111);
    endfunction

    logic          rx_meta_r;
    logic          rx_sync_r;
    logic          rx_s;
    state_t        state_r,  state_nxt;
    logic [CW-1:0] cnt_r,    cnt_nxt;
    logic [2:0]    bit_r,    bit_nxt;
    logic [7:0]    shift_r,  shift_nxt;
    logic [7:0]    byte_r,   byte_nxt;
    logic          ready_r,  ready_nxt;
    logic          ferr_r,   ferr_nxt;

    assign rx_s = rx_sync_r;

    // Two-flop synchronizer; reset to the idle (high) line level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Next-state, datapath and strobe computation
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        bit_nxt   = bit_r;
        shift_nxt = shift_r;
        byte_nxt  = byte_r;
        ready_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt = CNT_ZERO;
                if (!rx_s) begin
                    state_nxt = START;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt = CNT_ZERO;
                    bit_nxt = 3'd0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_nxt   = CNT_ZERO;
                    shift_nxt = {rx_s, shift_r[7:1]};
                    bit_nxt   = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        state_nxt = DATA;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit keeps back-to-back start bits catchable
                if (cnt_r == FULL_LAST) begin
                    cnt_nxt = CNT_ZERO;
                    if (rx_s) begin
                        state_nxt = IDLE;
                        if ((FILTER_RT == 1'b1) && is_realtime(shift_r)) begin
                            byte_nxt = byte_r;
                        end else begin
                            byte_nxt  = shift_r;
                            ready_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = BREAK;
                        ferr_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = BREAK;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, datapath and registered output strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            byte_r  <= 8'h00;
            ready_r <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            bit_r   <= bit_nxt;
            shift_r <= shift_nxt;
            byte_r  <= byte_nxt;
            ready_r <= ready_nxt;
            ferr_r  <= ferr_nxt;
        end
    end

    assign MIDIbyte      = byte_r;
    assign ready         = ready_r;
    assign framing_error = ferr_r;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx at 100 clocks per bit; one instance filters
// real-time bytes, a second instance on the same line passes them.
module tb_midi_uart_rx;

    localparam int CPB = 100;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rt_byte;
    logic       rt_ready;
    logic       rt_ferr;
    logic [7:0] nf_byte;
    logic       nf_ready;
    logic       nf_ferr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int rt_rdy   = 0;
    int rt_fe    = 0;
    int rt_both  = 0;
    int nf_rdy   = 0;
    int nf_fe    = 0;
    int nf_both  = 0;
    logic [7:0] rt_bytes [0:63];
    int         rt_cycs  [0:63];

    int start_cyc;
    int base_rdy;
    int base_fe;
    int base_nrdy;
    int base_nfe;

    midi_uart_rx #(.CLK_HZ(3_125_000), .BAUD(31_250), .FILTER_RT(1'b1)) dut_rt (
        .clk(clk), .reset(reset), .rx(rx),
        .MIDIbyte(rt_byte), .ready(rt_ready), .framing_error(rt_ferr)
    );

    midi_uart_rx #(.CLK_HZ(3_125_000), .BAUD(31_250), .FILTER_RT(1'b0)) dut_nf (
        .clk(clk), .reset(reset), .rx(rx),
        .MIDIbyte(nf_byte), .ready(nf_ready), .framing_error(nf_ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (rt_ready) begin
            rt_bytes[rt_rdy % 64] = rt_byte;
            rt_cycs[rt_rdy % 64]  = cyc;
            rt_rdy = rt_rdy + 1;
        end
        if (rt_ferr) rt_fe = rt_fe + 1;
        if (rt_ready && rt_ferr) rt_both = rt_both + 1;
        if (nf_ready) nf_rdy = nf_rdy + 1;
        if (nf_ferr) nf_fe = nf_fe + 1;
        if (nf_ready && nf_ferr) nf_both = nf_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, output int sc);
        rx = 1'b0;
        sc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        rx    = 1'b1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_byte", {24'd0, rt_byte}, 32'h00);
        chk("reset_ready", {31'd0, rt_ready}, 32'd0);
        chk("reset_ferr", {31'd0, rt_ferr}, 32'd0);
        reset = 1'b1;
        idle(20);

        // Single frame and latency
        base_rdy = rt_rdy;
        send(8'h90, 1'b1, start_cyc);
        idle(100);
        chk("single_count", rt_rdy - base_rdy, 32'd1);
        chk("single_byte", {24'd0, rt_byte}, 32'h90);
        chk("single_latency",
            {31'd0, ((rt_cycs[base_rdy % 64] - start_cyc) >= 950) &&
                    ((rt_cycs[base_rdy % 64] - start_cyc) <= 954)}, 32'd1);

        // Back-to-back frames with no idle gap
        base_rdy = rt_rdy;
        send(8'h90, 1'b1, start_cyc);
        send(8'h45, 1'b1, start_cyc);
        send(8'h67, 1'b1, start_cyc);
        idle(100);
        chk("b2b_count", rt_rdy - base_rdy, 32'd3);
        chk("b2b_byte0", {24'd0, rt_bytes[base_rdy % 64]}, 32'h90);
        chk("b2b_byte1", {24'd0, rt_bytes[(base_rdy + 1) % 64]}, 32'h45);
        chk("b2b_byte2", {24'd0, rt_bytes[(base_rdy + 2) % 64]}, 32'h67);
        chk("b2b_gap01", rt_cycs[(base_rdy + 1) % 64] - rt_cycs[base_rdy % 64], 32'd1000);
        chk("b2b_gap12", rt_cycs[(base_rdy + 2) % 64] - rt_cycs[(base_rdy + 1) % 64], 32'd1000);

        // Framing error followed by a held-low break
        base_rdy = rt_rdy;
        base_fe  = rt_fe;
        send(8'hB0, 1'b0, start_cyc);
        rx = 1'b0;
        repeat (500) @(negedge clk);
        idle(300);
        chk("ferr_count", rt_fe - base_fe, 32'd1);
        chk("ferr_no_ready", rt_rdy - base_rdy, 32'd0);
        chk("ferr_byte_held", {24'd0, rt_byte}, 32'h67);
        base_rdy = rt_rdy;
        send(8'h15, 1'b1, start_cyc);
        idle(100);
        chk("after_break_count", rt_rdy - base_rdy, 32'd1);
        chk("after_break_byte", {24'd0, rt_byte}, 32'h15);

        // Short glitch on the idle line
        base_rdy = rt_rdy;
        base_fe  = rt_fe;
        rx = 1'b0;
        repeat (30) @(negedge clk);
        idle(300);
        chk("glitch_no_ready", rt_rdy - base_rdy, 32'd0);
        chk("glitch_no_ferr", rt_fe - base_fe, 32'd0);
        send(8'h65, 1'b1, start_cyc);
        idle(100);
        chk("post_glitch_count", rt_rdy - base_rdy, 32'd1);
        chk("post_glitch_byte", {24'd0, rt_byte}, 32'h65);

        // Real-time filtering boundary
        base_rdy  = rt_rdy;
        base_nrdy = nf_rdy;
        send(8'hF8, 1'b1, start_cyc);
        idle(100);
        chk("rt_filtered_count", rt_rdy - base_rdy, 32'd0);
        chk("rt_filtered_byte", {24'd0, rt_byte}, 32'h65);
        chk("nf_pass_count", nf_rdy - base_nrdy, 32'd1);
        chk("nf_pass_byte", {24'd0, nf_byte}, 32'hF8);
        base_rdy = rt_rdy;
        send(8'hF7, 1'b1, start_cyc);
        idle(100);
        chk("f7_pass_count", rt_rdy - base_rdy, 32'd1);
        chk("f7_pass_byte", {24'd0, rt_byte}, 32'hF7);

        // Reset in the middle of data bit 4
        base_rdy  = rt_rdy;
        base_fe   = rt_fe;
        base_nrdy = nf_rdy;
        base_nfe  = nf_fe;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("in_reset_byte", {24'd0, rt_byte}, 32'h00);
        reset = 1'b1;
        idle(1200);
        chk("abort_no_ready", rt_rdy - base_rdy, 32'd0);
        chk("abort_no_ferr", rt_fe - base_fe, 32'd0);
        chk("abort_nf_no_strobe", (nf_rdy - base_nrdy) + (nf_fe - base_nfe), 32'd0);
        chk("abort_byte", {24'd0, rt_byte}, 32'h00);
        base_rdy  = rt_rdy;
        base_nrdy = nf_rdy;
        send(8'h05, 1'b1, start_cyc);
        idle(100);
        chk("post_reset_count", rt_rdy - base_rdy, 32'd1);
        chk("post_reset_byte", {24'd0, rt_byte}, 32'h05);
        chk("post_reset_nf_byte", {24'd0, nf_byte}, 32'h05);

        chk("never_both_rt", rt_both, 32'd0);
        chk("never_both_nf", nf_both, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/midi_uart_rx.md
MIDI_UART_RX -- requirements
Module: midi_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31_250, MIDI serial bit rate.
REQ-003 SHALL have parameter FILTER_RT, default 1, drop System Real-Time bytes (0xF8-0xFF) when 1.
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port rx  input  1  raw MIDI serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port MIDIbyte  output  8  last accepted received byte.
REQ-008 SHALL have port ready  output  1  one-cycle strobe: MIDIbyte holds a new byte.
REQ-009 SHALL have port framing_error  output  1  one-cycle strobe: stop bit sampled low.

Function
REQ-010 SHALL derive CLKS_PER_BIT = CLK_HZ/BAUD (integer division); bit counter width $clog2(CLKS_PER_BIT).
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: on rx_s == 0, clear bit counter and enter START.
REQ-014 START: after CLKS_PER_BIT/2 cycles, resample rx_s; if 0 enter DATA with counter cleared, if 1 (glitch) return to IDLE with no strobe.
REQ-015 DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit); 8 bits, LSB first, shifted into a shift register; after bit 7 enter STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, sample rx_s; if 1 accept the byte and enter IDLE; if 0 pulse framing_error and enter BREAK.
REQ-017 Accept: MIDIbyte loads shift register and ready = 1 for exactly one cycle, same cycle as the load.
REQ-018 With FILTER_RT = 1, an accepted byte >= 0xF8 SHALL NOT update MIDIbyte nor pulse ready; bytes 0xF0-0xF7 pass.
REQ-019 MIDIbyte SHALL hold its value between accepts, including across framing errors and filtered bytes.
REQ-020 BREAK: wait until rx_s == 1, then enter IDLE; no strobes while in BREAK.
REQ-021 Return to IDLE at mid-stop-bit so a start bit immediately following the stop bit is caught (back-to-back bytes, no idle gap).
REQ-022 Latency: ready asserts 2 + 9*CLKS_PER_BIT + CLKS_PER_BIT/2 cycles (+/-2) after the rx falling edge of the start bit.
REQ-023 ready and framing_error SHALL never assert in the same cycle.
REQ-024 Output MIDIbyte/ready are registered and directly compatible with the downstream MIDI decoder's byte/ready inputs.

Reset
REQ-025 While reset == 0: state IDLE, MIDIbyte = 0x00, ready = 0, framing_error = 0, counters and shift register 0, synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no strobe; after release, the first byte accepted is the next complete frame starting from a falling edge.
REQ-027 Reset deassertion while rx is low SHALL NOT start a frame until rx_s has been seen low from IDLE (i.e. treat as start only via REQ-013 after sync flops settle).

Verification
REQ-028 Bench SHALL use CLK_HZ = 3_125_000, BAUD = 31_250 (CLKS_PER_BIT = 100).
REQ-029 Frame 0x90 (start, bits LSB first, stop=1) -> one ready pulse ~952 cycles after start edge, MIDIbyte = 0x90.
REQ-030 Back-to-back frames 0x90, 0x45, 0x67 with no idle gap -> three ready pulses, MIDIbyte sequence 0x90, 0x45, 0x67, ~1000 cycles apart.
REQ-031 Frame 0xB0 with stop bit driven 0 then rx held low 500 cycles -> framing_error one pulse, no ready, MIDIbyte unchanged; next valid frame 0x15 -> ready, MIDIbyte = 0x15.
REQ-032 30-cycle low glitch on idle rx -> no ready, no framing_error, FSM back in IDLE; following frame 0x65 received correctly.
REQ-033 Frame 0xF8 with FILTER_RT = 1 -> no ready, MIDIbyte retains prior value; same frame with FILTER_RT = 0 -> ready, MIDIbyte = 0xF8.
REQ-034 reset pulled low at data bit 4 of frame 0x7F, released 50 cycles later -> no strobe, MIDIbyte = 0x00; subsequent frame 0x05 -> ready, MIDIbyte = 0x05.
